// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the bus source arbiter: source count and FSM encoding.
package bus_source_arbiter_pkg;

   localparam int N_SRC = 32;
   localparam int PTR_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_source_arbiter_rr_priority_pick.sv
// Round-robin winner search: first requesting source at or after Ptr, modulo 32.
module rr_priority_pick
   import bus_source_arbiter_pkg::*;
(
   input  logic [N_SRC-1:0] Req,
   input  logic [PTR_W-1:0] Ptr,
   output logic             Any,
   output logic [PTR_W-1:0] Win
);

   logic [N_SRC-1:0] rot;
   logic [PTR_W-1:0] idx;

   // Rotate so Ptr lands on bit 0, take the lowest set bit, then undo the rotation.
   always_comb begin
      rot = N_SRC'({Req, Req} >> Ptr);
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (rot[i]) idx = PTR_W'(i);
      end
   end

   assign Any = |Req;
   assign Win = idx + Ptr;

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter producing a registered one-hot drive select.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | no owner; pick next requester from Ptr, grant on next edge
//  S_GRANT | owner holds bus; exits on Release, Req drop, or hold timeout
//  S_GAP   | one turnaround cycle with Grant=0; pending Req ignored
module bus_source_arbiter
   import bus_source_arbiter_pkg::*;
#(
   parameter int N        = N_SRC,
   parameter int MAX_HOLD = 16,
   parameter int CW       = 5
)(
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic [N-1:0] Req,
   input  logic         Release,
   output logic [N-1:0] Grant,
   output logic         Busy,
   output logic         Timeout
);

   localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   arb_state_t       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     grant_d;
   logic             busy_d;
   logic             timeout_d;
   logic             any;
   logic [PTR_W-1:0] win;
   logic             drop;
   logic             hold_exp;

   rr_priority_pick u_pick (
      .Req (Req),
      .Ptr (ptr_q),
      .Any (any),
      .Win (win)
   );

   // A Release pulse or a withdrawn request both count as a normal release;
   // the timeout only reports when neither is present.
   assign drop     = Release || !Req[owner_q];
   assign hold_exp = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

   // State, pointer, hold counter and output flops.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         Grant   <= '0;
         Busy    <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         Grant   <= grant_d;
         Busy    <= busy_d;
         Timeout <= timeout_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      grant_d   = Grant;
      busy_d    = Busy;
      timeout_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (any) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               busy_d       = 1'b1;
               owner_d      = win;
               cnt_d        = '0;
               state_d      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (drop || hold_exp) begin
               grant_d   = '0;
               busy_d    = 1'b0;
               ptr_d     = owner_q + PTR_W'(1);
               timeout_d = hold_exp && !drop;
               state_d   = S_GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Encoder safety: never multi-hot, and Busy tracks Grant exactly.
   a_onehot0: assert property (@(posedge Clock) disable iff (!Reset_n) $onehot0(Grant));
   a_busy:    assert property (@(posedge Clock) disable iff (!Reset_n) Busy == (|Grant));

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_bus_source_arbiter;

   localparam int MAXH = 4;

   logic        Clock;
   logic        Reset_n;
   logic [31:0] Req;
   logic        Release;
   logic [31:0] Grant;
   logic        Busy;
   logic        Timeout;

   int n_checks = 0;
   int n_pass   = 0;

   bus_source_arbiter #(.N(32), .MAX_HOLD(MAXH), .CW(5)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Req     (Req),
      .Release (Release),
      .Grant   (Grant),
      .Busy    (Busy),
      .Timeout (Timeout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference model: ownership described as "who owns, for how many cycles",
   // with a mandatory empty slot after every ownership.
   int          m_owner;
   int          m_ptr;
   int          m_held;
   bit          m_gap;
   logic [31:0] exp_grant;
   logic        exp_timeout;

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         m_owner     = -1;
         m_ptr       = 0;
         m_held      = 0;
         m_gap       = 0;
         exp_grant   = '0;
         exp_timeout = 1'b0;
      end else begin
         exp_timeout = 1'b0;
         if (m_owner >= 0) begin
            bit dropped, expired;
            m_held  = m_held + 1;
            dropped = Release || !Req[m_owner];
            expired = (MAXH != 0) && (m_held == MAXH);
            if (dropped || expired) begin
               exp_timeout = expired && !dropped;
               m_ptr       = (m_owner + 1) % 32;
               m_owner     = -1;
               m_gap       = 1;
            end
         end else if (m_gap) begin
            m_gap = 0;
         end else if (Req != 0) begin
            for (int k = 0; k < 32; k++) begin
               if (m_owner < 0 && Req[(m_ptr + k) % 32]) m_owner = (m_ptr + k) % 32;
            end
            m_held = 0;
         end
         exp_grant = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
      end
   end

   task automatic cycle();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      Req     = '0;
      Release = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      Release = 1'b0;
      Req     = 32'hFFFF_FFFF;
      cycle();
      cycle();
      n_checks++;
      if (Grant !== 32'h0 || Busy !== 1'b0 || Timeout !== 1'b0)
         $display("FAIL reset_state grant=%h busy=%b timeout=%b exp grant=0 busy=0 timeout=0", Grant, Busy, Timeout);
      else n_pass++;
      Reset_n = 1'b1;
      cycle();
      n_checks++;
      if (Grant !== 32'h1 || Busy !== 1'b1)
         $display("FAIL reset_first_grant grant=%h busy=%b exp grant=00000001 busy=1", Grant, Busy);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_seq [5] = '{32'h10, 32'h0, 32'h80, 32'h0, 32'h10};
      logic [31:0] got_seq [5];
      int          g;
      do_reset();
      Req = 32'h0000_0090;
      cycle();
      got_seq[0] = Grant;
      g = 1;
      for (int own = 0; own < 2; own++) begin
         Release = 1'b1;
         cycle();
         got_seq[g] = Grant;
         g++;
         Release = 1'b1;
         cycle();
         Release = 1'b0;
         n_checks++;
         if (Grant !== 32'h0)
            $display("FAIL rr_gap_release_ignored grant=%h exp=00000000", Grant);
         else n_pass++;
         cycle();
         got_seq[g] = Grant;
         g++;
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (got_seq[i] !== exp_seq[i])
            $display("FAIL rr_sequence[%0d] grant=%h exp=%h", i, got_seq[i], exp_seq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      Req = 32'h4000_0000;
      cycle();
      Release = 1'b1;
      cycle();
      Release = 1'b0;
      Req = 32'h8000_0001;
      cycle();
      cycle();
      n_checks++;
      if (Grant !== 32'h8000_0000)
         $display("FAIL wrap_src31 grant=%h exp=80000000", Grant);
      else n_pass++;
      Release = 1'b1;
      cycle();
      Release = 1'b0;
      cycle();
      cycle();
      n_checks++;
      if (Grant !== 32'h1)
         $display("FAIL wrap_to_src0 grant=%h exp=00000001", Grant);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int held;
      do_reset();
      Req  = 32'h8;
      held = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (Grant === 32'h8) held++;
         else break;
      end
      n_checks++;
      if (held != MAXH)
         $display("FAIL timeout_hold_len cycles=%0d exp=%0d", held, MAXH);
      else n_pass++;
      n_checks++;
      if (Grant !== 32'h0 || Timeout !== 1'b1)
         $display("FAIL timeout_pulse grant=%h timeout=%b exp grant=00000000 timeout=1", Grant, Timeout);
      else n_pass++;
      cycle();
      n_checks++;
      if (Timeout !== 1'b0 || Grant !== 32'h0)
         $display("FAIL timeout_one_cycle grant=%h timeout=%b exp grant=00000000 timeout=0", Grant, Timeout);
      else n_pass++;
      cycle();
      n_checks++;
      if (Grant !== 32'h8)
         $display("FAIL timeout_regrant grant=%h exp=00000008", Grant);
      else n_pass++;
   endtask

   task automatic test_release_coincide();
      for (int mode = 0; mode < 2; mode++) begin
         do_reset();
         Req = 32'h8;
         cycle();
         for (int i = 0; i < MAXH - 1; i++) cycle();
         n_checks++;
         if (Grant !== 32'h8)
            $display("FAIL coincide_hold[%0d] grant=%h exp=00000008", mode, Grant);
         else n_pass++;
         if (mode == 0) Release = 1'b1;
         else Req = 32'h0;
         cycle();
         Release = 1'b0;
         n_checks++;
         if (Grant !== 32'h0 || Timeout !== 1'b0)
            $display("FAIL coincide_no_timeout[%0d] grant=%h timeout=%b exp grant=00000000 timeout=0", mode, Grant, Timeout);
         else n_pass++;
      end
      do_reset();
      Req = 32'h20;
      cycle();
      cycle();
      Req = 32'h0;
      cycle();
      n_checks++;
      if (Grant !== 32'h0 || Timeout !== 1'b0 || Busy !== 1'b0)
         $display("FAIL req_drop grant=%h timeout=%b busy=%b exp 0/0/0", Grant, Timeout, Busy);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      Req = 32'h400;
      cycle();
      n_checks++;
      if (Grant !== 32'h400)
         $display("FAIL async_pre grant=%h exp=00000400", Grant);
      else n_pass++;
      #2 Reset_n = 1'b0;
      #1;
      n_checks++;
      if (Grant !== 32'h0 || Busy !== 1'b0)
         $display("FAIL async_reset grant=%h busy=%b exp grant=00000000 busy=0", Grant, Busy);
      else n_pass++;
      @(negedge Clock);
      Req     = 32'h401;
      Reset_n = 1'b1;
      cycle();
      n_checks++;
      if (Grant !== 32'h1)
         $display("FAIL async_ptr_cleared grant=%h exp=00000001", Grant);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      int code;
      errs = 0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         n_checks++;
         if (Grant !== exp_grant || Timeout !== exp_timeout || Busy !== (exp_grant != 0)) begin
            if (errs < 10)
               $display("FAIL random_cycle%0d grant=%h timeout=%b busy=%b exp grant=%h timeout=%b",
                        c, Grant, Timeout, Busy, exp_grant, exp_timeout);
            errs++;
         end else n_pass++;
         if (Grant != 0) begin
            code = -1;
            for (int i = 0; i < 32; i++) if (Grant[i]) code = i;
            n_checks++;
            if (code != m_owner) begin
               if (errs < 10) $display("FAIL random_code%0d code=%0d exp=%0d", c, code, m_owner);
               errs++;
            end else n_pass++;
         end
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: Req = $urandom;
               1: Req = $urandom & $urandom & $urandom;
               default: Req = 32'h1 << $urandom_range(0, 31);
            endcase
         end
         Release = ($urandom_range(0, 5) == 0);
         cycle();
      end
      Release = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      Req     = '0;
      Release = 1'b0;
      test_reset();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_release_coincide();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
